int_scheduler: RTL

Fixed-priority interrupt scheduler for BrainForge8 that sits between the 16 interrupt sources (external INT lines, DMA, stack faults, reset, software, IRQ) and the CPU core. It latches rising edges into a pending register and applies a software-programmable mask. One request at a time is presented to the core through a valid/ack handshake, and the block holds it in-service until end-of-interrupt. Configuration and status are reached through a small 8-bit register port.

---
 rtl/int_scheduler_pkg.sv | 25 ++
 rtl/int_scheduler_prio_enc.sv | 21 ++
 rtl/int_scheduler.sv | 87 ++++++++
 3 files changed

// File: rtl/int_scheduler_pkg.sv
// int_scheduler_pkg: register map, FSM encoding and interrupt IDs shared by the scheduler and the interrupt controller
package int_scheduler_pkg;
  localparam logic [2:0] REG_MASK_LO = 3'd0;
  localparam logic [2:0] REG_MASK_HI = 3'd1;
  localparam logic [2:0] REG_PEND_LO = 3'd2;
  localparam logic [2:0] REG_PEND_HI = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_OVF     = 3'd5;
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_REQ     = 2'b01;
  localparam logic [1:0] ST_SERVICE = 2'b10;
  localparam logic [3:0] ID_INT0    = 4'd0;
  localparam logic [3:0] ID_INT1    = 4'd1;
  localparam logic [3:0] ID_INT2    = 4'd2;
  localparam logic [3:0] ID_INT3    = 4'd3;
  localparam logic [3:0] ID_DMA     = 4'd4;
  localparam logic [3:0] ID_STK_OVF = 4'd5;
  localparam logic [3:0] ID_STK_UNF = 4'd6;
  localparam logic [3:0] ID_SWI     = 4'd7;
  localparam logic [3:0] ID_RST     = 4'd8;
  localparam logic [3:0] ID_IRQ     = 4'd9;
  function automatic logic [15:0] id_bit(input logic [3:0] id);
    return 16'd1 << id;
  endfunction
endpackage

// File: rtl/int_scheduler_prio_enc.sv
// int_prio_enc: combinational 16-to-4 priority encoder, RST_ID first then lowest eligible ID
// Ports: pend (pending bits), mask (1 = masked), id (winner), hit (any eligible)
module int_prio_enc
  import int_scheduler_pkg::*;
#(
  parameter logic [3:0] RST_ID = ID_RST
) (
  input  logic [15:0] pend,
  input  logic [15:0] mask,
  output logic [3:0]  id,
  output logic        hit
);
  logic [15:0] elig;
  assign elig = (pend & ~mask) | (pend & id_bit(RST_ID));
  assign hit = |elig;
  always_comb begin
    id = '0;
    for (int i = 15; i >= 0; i--) if (elig[i]) id = 4'(i);
    if (pend[RST_ID]) id = RST_ID;
  end
endmodule

// File: rtl/int_scheduler.sv
// int_scheduler: fixed-priority interrupt scheduler with edge-latched pending bits, mask and valid/ack/EOI handshake
// Ports: CLK, RST (sync, active-low), SRC[15:0] sources, IRQ_VALID/IRQ_ID/IRQ_ACK request handshake,
//        IN_SERVICE/EOI service window, CFG_WE/CFG_ADDR/CFG_WDATA/CFG_RDATA 8-bit register port
// Option: define INT_SCHED_OVF_EN to add the saturating coalesced-edge counter at address 5
module int_scheduler
  import int_scheduler_pkg::*;
#(
  parameter logic [15:0] MASK_RESET = 16'hFFFF,
  parameter logic [3:0]  RST_ID     = 4'b1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] SRC,
  output logic        IRQ_VALID,
  output logic [3:0]  IRQ_ID,
  input  logic        IRQ_ACK,
  output logic        IN_SERVICE,
  input  logic        EOI,
  input  logic        CFG_WE,
  input  logic [2:0]  CFG_ADDR,
  input  logic [7:0]  CFG_WDATA,
  output logic [7:0]  CFG_RDATA
);
  logic [15:0] src_q, pend, mask, edges, w1c, gclr, pend_n, mask_n;
  logic [1:0]  state, state_n;
  logic [3:0]  irq_id, win_id;
  logic        any_elig, grant;
  logic [7:0]  rdata_n, ovf_rd;
  int_prio_enc #(.RST_ID(RST_ID)) u_enc (
    .pend(pend),
    .mask(mask),
    .id  (win_id),
    .hit (any_elig)
  );
  assign edges = SRC & ~src_q;
  assign grant = state == ST_IDLE && any_elig;
  assign gclr  = grant ? id_bit(win_id) : '0;
  assign w1c   = !CFG_WE ? '0 :
                 CFG_ADDR == REG_PEND_LO ? {8'h00, CFG_WDATA} :
                 CFG_ADDR == REG_PEND_HI ? {CFG_WDATA, 8'h00} : '0;
  // A same-cycle edge wins over both the grant clear and a W1C
  assign pend_n = (pend & ~w1c & ~gclr) | edges;
  assign mask_n = (!CFG_WE ? mask :
                   CFG_ADDR == REG_MASK_LO ? {mask[15:8], CFG_WDATA} :
                   CFG_ADDR == REG_MASK_HI ? {CFG_WDATA, mask[7:0]} : mask) & ~id_bit(RST_ID);
  assign state_n = state == ST_IDLE    ? (any_elig ? ST_REQ : ST_IDLE) :
                   state == ST_REQ     ? (IRQ_ACK ? ST_SERVICE : ST_REQ) :
                   state == ST_SERVICE ? (EOI ? ST_IDLE : ST_SERVICE) : ST_IDLE;
  assign rdata_n = CFG_ADDR == REG_MASK_LO ? mask[7:0] :
                   CFG_ADDR == REG_MASK_HI ? mask[15:8] :
                   CFG_ADDR == REG_PEND_LO ? pend[7:0] :
                   CFG_ADDR == REG_PEND_HI ? pend[15:8] :
                   CFG_ADDR == REG_STATUS  ? {2'b00, state, irq_id} :
                   CFG_ADDR == REG_OVF     ? ovf_rd : 8'h00;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      src_q     <= '0;
      pend      <= '0;
      mask      <= MASK_RESET & ~id_bit(RST_ID);
      state     <= ST_IDLE;
      irq_id    <= '0;
      CFG_RDATA <= '0;
    end else begin
      src_q     <= SRC;
      pend      <= pend_n;
      mask      <= mask_n;
      state     <= state_n;
      irq_id    <= grant ? win_id : irq_id;
      CFG_RDATA <= rdata_n;
    end
  end
`ifdef INT_SCHED_OVF_EN
  logic [7:0] ovf_cnt;
  // Simultaneous drops on several bits count once per cycle
  always_ff @(posedge CLK) begin
    if (!RST) ovf_cnt <= '0;
    else if (CFG_WE && CFG_ADDR == REG_OVF) ovf_cnt <= '0;
    else if (|(edges & pend) && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end
  assign ovf_rd = ovf_cnt;
`else
  assign ovf_rd = 8'h00;
`endif
  assign IRQ_VALID  = state == ST_REQ;
  assign IN_SERVICE = state == ST_SERVICE;
  assign IRQ_ID     = irq_id;
endmodule
